// File: rtl/regfile.sv
// ---------------------------------------------------------------------------
// regfile
//   General-purpose register file for the five-stage pipeline. The WB stage
//   writes one register per clock edge. The ID stage reads two registers
//   combinationally. A write and a read of the same register in one cycle
//   return the data being written, so WB and ID can overlap without a hazard.
//   Register 0 is hardwired to zero.
// ---------------------------------------------------------------------------
module regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);

  // Architectural register storage; entry 0 is never written.
  logic [DATA_W-1:0] regs [NUM_REGS];

  // A write is only taken when it targets a real register.
  logic wr_valid;
  assign wr_valid = we && (waddr != '0);

  // Read-port rule, shared by both ports. Priority: reset, enable, $0,
  // same-cycle bypass from the write port, then stored contents.
  function automatic logic [DATA_W-1:0] read_port(
    input logic              rst_v,
    input logic              re_v,
    input logic [ADDR_W-1:0] raddr_v,
    input logic              wr_valid_v,
    input logic [ADDR_W-1:0] waddr_v,
    input logic [DATA_W-1:0] wdata_v,
    input logic [DATA_W-1:0] stored_v
  );
    logic [DATA_W-1:0] r;
    r = '0;
    if (!rst_v || !re_v || (raddr_v == '0)) begin
      r = '0;
    end else if (wr_valid_v && (waddr_v == raddr_v)) begin
      r = wdata_v;
    end else begin
      r = stored_v;
    end
    return r;
  endfunction

  // Register array update: asynchronous clear, then one write per edge.
  // NOTE: this is a flop array rather than an SRAM macro, so every entry can
  // be (and is) cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        // NOTE: non-blocking assignments in clocked blocks so every flop
        // samples pre-edge values regardless of statement order.
        regs[i] <= '0;
      end
    end else if (wr_valid) begin
      regs[waddr] <= wdata;
    end
  end

  // Read port 1: purely combinational, zero-cycle.
  // NOTE: read_port assigns its result on every path (default first), so no
  // latch can be inferred from this block.
  always_comb begin
    rdata1 = read_port(rst, re1, raddr1, wr_valid, waddr, wdata, regs[raddr1]);
  end

  // Read port 2: same rules as port 1, evaluated independently.
  always_comb begin
    rdata2 = read_port(rst, re2, raddr2, wr_valid, waddr, wdata, regs[raddr2]);
  end

endmodule

// File: tb/tb_regfile.sv
// ---------------------------------------------------------------------------
// tb_regfile
//   Directed steps followed by a randomized run, all compared against a plain
//   array model of the architectural registers kept in the bench.
// ---------------------------------------------------------------------------
module tb_regfile;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: what each register architecturally holds.
  logic [31:0] model [32];

  regfile #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re1    (re1),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .re2    (re2),
    .raddr2 (raddr2),
    .rdata2 (rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the bench only waits on its own clock, but never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to have finished", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected read value from the architectural rules.
  function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] a);
    if (!rst || !re || a == 5'd0) return 32'h0;
    if (we && waddr == a) return wdata;
    return model[a];
  endfunction

  task automatic set_rst(input logic v);
    rst = v;
    if (!v) for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  // One rising edge; model commits the write, then settle away from the edge.
  task automatic tick();
    @(posedge clk);
    if (rst && we && waddr != 5'd0) model[waddr] = wdata;
    #1;
  endtask

  // Compare both ports with the model after inputs have settled.
  task automatic chk_ports(input string tag);
    #1;
    check({tag, "_p1"}, rdata1, exp_rd(re1, raddr1));
    check({tag, "_p2"}, rdata2, exp_rd(re2, raddr2));
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    we = 1'b0; waddr = 5'd0; wdata = 32'h0;
    re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd31;

    // 1. Reset held three cycles, ports read zero; then everything reads 0.
    set_rst(1'b0);
    #2;
    for (int c = 0; c < 3; c++) begin
      check("rst_hold_p1", rdata1, 32'h0);
      check("rst_hold_p2", rdata2, 32'h0);
      tick();
    end
    set_rst(1'b1);
    tick();
    for (int a = 0; a < 32; a++) begin
      raddr1 = 5'(a); raddr2 = 5'(31 - a);
      #1;
      check("post_rst_zero_p1", rdata1, 32'h0);
      check("post_rst_zero_p2", rdata2, 32'h0);
    end

    // 2. Simple write, visible after the edge; neighbour untouched.
    write(5'd7, 32'hDEADBEEF);
    raddr1 = 5'd7; raddr2 = 5'd8;
    #1;
    check("wr7_rd1", rdata1, 32'hDEADBEEF);
    check("rd8_zero", rdata2, 32'h0);

    // 3. Bypass on both ports before the edge, then stored after it.
    we = 1'b1; waddr = 5'd12; wdata = 32'h1234_5678;
    raddr1 = 5'd12; raddr2 = 5'd12;
    #1;
    check("bypass_p1", rdata1, 32'h1234_5678);
    check("bypass_p2", rdata2, 32'h1234_5678);
    tick();
    we = 1'b0;
    #1;
    check("stored12_p1", rdata1, 32'h1234_5678);

    // 4. Write to $0 is dropped, both during and after the edge.
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; raddr1 = 5'd0;
    #1;
    check("r0_same_cycle", rdata1, 32'h0);
    tick();
    we = 1'b0;
    #1;
    check("r0_after_edge", rdata1, 32'h0);

    // 5. Read enable gates the output.
    write(5'd3, 32'hA5A5_A5A5);
    re1 = 1'b0; raddr1 = 5'd3;
    #1;
    check("re1_off", rdata1, 32'h0);
    re1 = 1'b1;
    #1;
    check("re1_on", rdata1, 32'hA5A5_A5A5);

    // 6. Fill with own index, async reset mid-cycle with a write pending.
    for (int a = 1; a < 32; a++) write(5'(a), 32'(a));
    raddr1 = 5'd17; raddr2 = 5'd31;
    #1;
    check("fill17", rdata1, 32'd17);
    check("fill31", rdata2, 32'd31);
    we = 1'b1; waddr = 5'd9; wdata = 32'hCAFE_F00D;
    #2;
    set_rst(1'b0);
    #1;
    check("async_rst_p1", rdata1, 32'h0);
    check("async_rst_p2", rdata2, 32'h0);
    tick();
    we = 1'b0;
    set_rst(1'b1);
    for (int a = 0; a < 32; a++) begin
      raddr1 = 5'(a); raddr2 = 5'(31 - a);
      #1;
      check("after_midrst_p1", rdata1, 32'h0);
      check("after_midrst_p2", rdata2, 32'h0);
    end
    // First write after release is accepted at the next edge.
    write(5'd9, 32'h0BAD_CAFE);
    raddr1 = 5'd9;
    #1;
    check("first_wr_after_rst", rdata1, 32'h0BAD_CAFE);

    // 7. Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      we     = ($urandom_range(0, 3) != 0);
      waddr  = 5'($urandom_range(0, 31));
      wdata  = $urandom;
      re1    = ($urandom_range(0, 7) != 0);
      re2    = ($urandom_range(0, 7) != 0);
      raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      raddr2 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      chk_ports("rand");
      if ($urandom_range(0, 199) == 0) begin
        set_rst(1'b0);
        chk_ports("rand_rst");
        tick();
        set_rst(1'b1);
        chk_ports("rand_rst_rel");
      end else begin
        tick();
      end
    end

    // Sweep final contents.
    we = 1'b0; re1 = 1'b1; re2 = 1'b1;
    for (int a = 0; a < 32; a++) begin
      raddr1 = 5'(a); raddr2 = 5'(a);
      chk_ports("final_sweep");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
